paillier_seq_ctrl: RTL and testbench

PAILLIER_SEQ_CTRL -- requirements
Module: paillier_seq_ctrl

---
 rtl/paillier_seq_ctrl_if.sv | 46 ++++
 rtl/paillier_seq_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_paillier_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/paillier_seq_ctrl_if.sv
// Host/engine-facing bus of the Paillier sequence controller.
// Suffixes name the direction as seen from the controller (slave modport).
interface paillier_seq_ctrl_if #(
  parameter int K = 128
);
  logic [2:0]   task_cmd_i;
  logic         task_req_i;
  logic         task_busy_o;
  logic         task_done_o;
  logic         task_err_o;
  logic [K-1:0] in_a_i;
  logic [K-1:0] in_b_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         me_start_o;
  logic         mm_start_o;
  logic [K-1:0] me_x_o;
  logic [K-1:0] me_y_o;
  logic         me_xy_valid_o;
  logic [K-1:0] mm_x_o;
  logic [K-1:0] mm_y_o;
  logic         mm_xy_valid_o;
  logic [K-1:0] me_res_i;
  logic         me_res_valid_i;
  logic [K-1:0] mm_res_i;
  logic         mm_res_valid_i;
  logic [K-1:0] out_data_o;
  logic         out_valid_o;
  logic         out_last_o;

  modport slave (
    input  task_cmd_i, task_req_i, in_a_i, in_b_i, in_valid_i,
           me_res_i, me_res_valid_i, mm_res_i, mm_res_valid_i,
    output task_busy_o, task_done_o, task_err_o, in_ready_o,
           me_start_o, mm_start_o, me_x_o, me_y_o, me_xy_valid_o,
           mm_x_o, mm_y_o, mm_xy_valid_o, out_data_o, out_valid_o, out_last_o
  );

  modport master (
    output task_cmd_i, task_req_i, in_a_i, in_b_i, in_valid_i,
           me_res_i, me_res_valid_i, mm_res_i, mm_res_valid_i,
    input  task_busy_o, task_done_o, task_err_o, in_ready_o,
           me_start_o, mm_start_o, me_x_o, me_y_o, me_xy_valid_o,
           mm_x_o, mm_y_o, mm_xy_valid_o, out_data_o, out_valid_o, out_last_o
  );
endinterface

// File: rtl/paillier_seq_ctrl.sv
// Sequences modular-exponentiation / modular-multiplication engines for
// Paillier ENC, HOMO_ADD and SCALAR_MUL over N words of K bits.
//
// state     | meaning
// IDLE      | waiting for task_req
// ME_RUN    | feeding/collecting the exponentiation engine
// MM_RUN    | feeding/collecting the multiplication engine
// COMB_FEED | ENC: replaying BME x BMM into the multiplication engine
// COMB_WAIT | ENC: streaming the combine results out
// DONE      | one cycle to raise task_done
module paillier_seq_ctrl #(
  parameter int K = 128,
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  paillier_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] NM1_C = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, ME_RUN, MM_RUN, COMB_FEED, COMB_WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          enc_q, enc_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, res_cnt_q, res_cnt_d, feed_cnt_q, feed_cnt_d;
  logic          carry_q, carry_d;
  logic          me_start_q, me_start_d, mm_start_q, mm_start_d;
  logic [K-1:0]  me_x_q, me_x_d, me_y_q, me_y_d, mm_x_q, mm_x_d, mm_y_q, mm_y_d;
  logic          me_xyv_q, me_xyv_d, mm_xyv_q, mm_xyv_d;
  logic [K-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          done_q, done_d, err_q, err_d;

  logic [K-1:0]  bme_q [N];
  logic [K-1:0]  bmm_q [N];
  logic          bme_we, bmm_we;
  logic [K-1:0]  bmm_wdata;
  logic [IW-1:0] res_idx, feed_idx;

  logic          legal, in_ready, in_acc, me_acc, mm_acc, res_acc, res_last, stream;
  logic [K-1:0]  res_word;

  always_comb begin
    legal    = bus.task_cmd_i inside {3'b000, 3'b010, 3'b011};
    in_ready = (state_q == ME_RUN || state_q == MM_RUN) && (in_cnt_q < N_C);
    in_acc   = in_ready && bus.in_valid_i;
    me_acc   = bus.me_res_valid_i && (state_q == ME_RUN) && (res_cnt_q < N_C);
    mm_acc   = bus.mm_res_valid_i && (state_q inside {MM_RUN, COMB_FEED, COMB_WAIT})
               && (res_cnt_q < N_C);
    res_acc  = me_acc || mm_acc;
    res_word = me_acc ? bus.me_res_i : bus.mm_res_i;
    res_last = res_acc && (res_cnt_q == NM1_C);
    // ENC intermediate phases fill buffers instead of producing output
    stream   = res_acc && !(enc_q && (state_q == ME_RUN || state_q == MM_RUN));
    res_idx  = res_cnt_q[IW-1:0];
    feed_idx = feed_cnt_q[IW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    in_cnt_d    = in_cnt_q;
    res_cnt_d   = res_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    carry_d     = carry_q;
    me_start_d  = 1'b0;
    mm_start_d  = 1'b0;
    me_x_d      = me_x_q;
    me_y_d      = me_y_q;
    mm_x_d      = mm_x_q;
    mm_y_d      = mm_y_q;
    me_xyv_d    = 1'b0;
    mm_xyv_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bme_we      = 1'b0;
    bmm_we      = 1'b0;
    bmm_wdata   = res_word + {{(K-1){1'b0}}, carry_q};

    if (in_acc) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (state_q == ME_RUN) begin
        me_x_d   = bus.in_a_i;
        me_y_d   = bus.in_b_i;
        me_xyv_d = 1'b1;
      end else begin
        mm_x_d   = bus.in_a_i;
        mm_y_d   = bus.in_b_i;
        mm_xyv_d = 1'b1;
      end
    end
    if (res_acc) res_cnt_d = res_cnt_q + 1'b1;
    if (stream) begin
      out_data_d  = res_word;
      out_valid_d = 1'b1;
      out_last_d  = res_last;
    end

    case (state_q)
      IDLE: begin
        if (bus.task_req_i) begin
          if (legal) begin
            enc_d      = (bus.task_cmd_i == 3'b000);
            in_cnt_d   = '0;
            res_cnt_d  = '0;
            feed_cnt_d = '0;
            carry_d    = 1'b1;
            if (bus.task_cmd_i == 3'b010) begin
              mm_start_d = 1'b1;
              state_d    = MM_RUN;
            end else begin
              me_start_d = 1'b1;
              state_d    = ME_RUN;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ME_RUN: begin
        bme_we = me_acc && enc_q;
        if (res_last) begin
          if (enc_q) begin
            state_d    = MM_RUN;
            mm_start_d = 1'b1;
            in_cnt_d   = '0;
            res_cnt_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      MM_RUN: begin
        if (enc_q && mm_acc) begin
          bmm_we  = 1'b1;
          carry_d = carry_q && (bus.mm_res_i == {K{1'b1}});
        end
        if (res_last) begin
          if (enc_q) begin
            state_d    = COMB_FEED;
            mm_start_d = 1'b1;
            res_cnt_d  = '0;
            feed_cnt_d = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      COMB_FEED: begin
        mm_x_d     = bme_q[feed_idx];
        mm_y_d     = bmm_q[feed_idx];
        mm_xyv_d   = 1'b1;
        feed_cnt_d = feed_cnt_q + 1'b1;
        if (feed_cnt_q == NM1_C) state_d = res_last ? DONE : COMB_WAIT;
      end
      COMB_WAIT: begin
        if (res_last) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      enc_q       <= 1'b0;
      in_cnt_q    <= '0;
      res_cnt_q   <= '0;
      feed_cnt_q  <= '0;
      carry_q     <= 1'b0;
      me_start_q  <= 1'b0;
      mm_start_q  <= 1'b0;
      me_x_q      <= '0;
      me_y_q      <= '0;
      mm_x_q      <= '0;
      mm_y_q      <= '0;
      me_xyv_q    <= 1'b0;
      mm_xyv_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      in_cnt_q    <= in_cnt_d;
      res_cnt_q   <= res_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      carry_q     <= carry_d;
      me_start_q  <= me_start_d;
      mm_start_q  <= mm_start_d;
      me_x_q      <= me_x_d;
      me_y_q      <= me_y_d;
      mm_x_q      <= mm_x_d;
      mm_y_q      <= mm_y_d;
      me_xyv_q    <= me_xyv_d;
      mm_xyv_q    <= mm_xyv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Operand buffers hold data only between phases of one task; no reset needed
  always_ff @(posedge clk) begin
    if (bme_we) bme_q[res_idx] <= res_word;
    if (bmm_we) bmm_q[res_idx] <= bmm_wdata;
  end

  assign bus.task_busy_o   = (state_q != IDLE);
  assign bus.task_done_o   = done_q;
  assign bus.task_err_o    = err_q;
  assign bus.in_ready_o    = in_ready;
  assign bus.me_start_o    = me_start_q;
  assign bus.mm_start_o    = mm_start_q;
  assign bus.me_x_o        = me_x_q;
  assign bus.me_y_o        = me_y_q;
  assign bus.me_xy_valid_o = me_xyv_q;
  assign bus.mm_x_o        = mm_x_q;
  assign bus.mm_y_o        = mm_y_q;
  assign bus.mm_xy_valid_o = mm_xyv_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_last_o    = out_last_q;
endmodule

// File: tb/tb_paillier_seq_ctrl.sv
// Randomized bench for paillier_seq_ctrl (K=8, N=4) with behavioural engines
// driven from the bench and a task-level reference of the expected traffic.
module tb_paillier_seq_ctrl;
  localparam int K = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paillier_seq_ctrl_if #(.K(K)) bus ();
  paillier_seq_ctrl #(.K(K), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [K-1:0]   out_q[$];
  logic           last_q[$];
  logic [2*K-1:0] mex_q[$], mmx_q[$];
  logic [2*K-1:0] exp_mex[$], exp_mmx[$];
  logic [K-1:0]   exp_out[$];
  int me_starts, mm_starts, errs, dones, last_cyc, done_cyc;
  logic done_busy;

  logic [K-1:0] r_me [N];
  logic [K-1:0] r_mm [N];
  logic [K-1:0] r_cb [N];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.out_valid_o) begin
      out_q.push_back(bus.out_data_o);
      last_q.push_back(bus.out_last_o);
      if (bus.out_last_o) last_cyc = cyc;
    end
    if (bus.me_xy_valid_o) mex_q.push_back({bus.me_x_o, bus.me_y_o});
    if (bus.mm_xy_valid_o) mmx_q.push_back({bus.mm_x_o, bus.mm_y_o});
    if (bus.me_start_o) me_starts++;
    if (bus.mm_start_o) mm_starts++;
    if (bus.task_err_o) errs++;
    if (bus.task_done_o) begin
      dones++;
      done_cyc  = cyc;
      done_busy = bus.task_busy_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete(); last_q.delete(); mex_q.delete(); mmx_q.delete();
    exp_mex.delete(); exp_mmx.delete(); exp_out.delete();
    me_starts = 0; mm_starts = 0; errs = 0; dones = 0;
    last_cyc = -1; done_cyc = -1; done_busy = 1'b1;
  endtask

  task automatic randomize_res();
    for (int i = 0; i < N; i++) begin
      r_me[i] = K'($urandom);
      r_mm[i] = K'($urandom);
      r_cb[i] = K'($urandom);
    end
  endtask

  // Feed N operand words; results for word i-1 ride along with word i.
  task automatic run_phase(input bit use_me, input logic [K-1:0] res [N], input bit spurious);
    for (int i = 0; i <= N; i++) begin
      logic [K-1:0] a, b;
      a = K'($urandom);
      b = K'($urandom);
      if (i < N) begin
        chk("in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        bus.in_valid_i = 1'b1;
        bus.in_a_i = a;
        bus.in_b_i = b;
        if (use_me) exp_mex.push_back({a, b});
        else        exp_mmx.push_back({a, b});
      end else begin
        bus.in_valid_i = 1'b0;
      end
      bus.me_res_valid_i = use_me && (i > 0);
      bus.mm_res_valid_i = !use_me && (i > 0);
      if (i > 0) begin
        bus.me_res_i = res[i-1];
        bus.mm_res_i = res[i-1];
      end
      bus.task_req_i = spurious;
      bus.task_cmd_i = 3'($urandom);
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.me_res_valid_i = 1'b0;
    bus.mm_res_valid_i = 1'b0;
    bus.task_req_i = 1'b0;
    if (spurious) begin
      bus.me_res_valid_i = 1'b1;
      bus.me_res_i = K'($urandom);
      tick();
      bus.me_res_valid_i = 1'b0;
    end
  endtask

  task automatic wait_done_and_check(input logic [2:0] cmd);
    for (int t = 0; t < 20 && dones == 0; t++) tick();
    tick();
    chk("done_cnt", dones, 1);
    chk("done_lat", done_cyc - last_cyc, 1);
    chk("busy_at_done", {31'd0, done_busy}, 0);
    chk("out_cnt", out_q.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < out_q.size()) begin
        chk("out_data", out_q[i], exp_out[i]);
        chk("out_last", {31'd0, last_q[i]}, (i == N - 1) ? 1 : 0);
      end
    end
    chk("me_xy_cnt", mex_q.size(), exp_mex.size());
    for (int i = 0; i < exp_mex.size(); i++)
      if (i < mex_q.size()) chk("me_xy", mex_q[i], exp_mex[i]);
    chk("mm_xy_cnt", mmx_q.size(), exp_mmx.size());
    for (int i = 0; i < exp_mmx.size(); i++)
      if (i < mmx_q.size()) chk("mm_xy", mmx_q[i], exp_mmx[i]);
    chk("me_starts", me_starts, (cmd == 3'b010) ? 0 : 1);
    chk("mm_starts", mm_starts, (cmd == 3'b010) ? 1 : (cmd == 3'b000) ? 2 : 0);
    chk("errs", errs, 0);
  endtask

  task automatic run_task(input logic [2:0] cmd, input bit spurious);
    logic [N*K-1:0] w;
    clear_mon();
    bus.task_cmd_i = cmd;
    bus.task_req_i = 1'b1;
    tick();
    bus.task_req_i = 1'b0;
    if (!(cmd inside {3'b000, 3'b010, 3'b011})) begin
      tick(); tick();
      chk("err_cnt", errs, 1);
      chk("illegal_starts", me_starts + mm_starts, 0);
      chk("illegal_busy", {31'd0, bus.task_busy_o}, 0);
      chk("illegal_done", dones, 0);
      return;
    end
    chk("busy", {31'd0, bus.task_busy_o}, 1);
    if (cmd == 3'b010) begin
      run_phase(1'b0, r_mm, 1'b0);
      for (int i = 0; i < N; i++) exp_out.push_back(r_mm[i]);
    end else if (cmd == 3'b011) begin
      run_phase(1'b1, r_me, spurious);
      for (int i = 0; i < N; i++) exp_out.push_back(r_me[i]);
    end else begin
      run_phase(1'b1, r_me, 1'b0);
      run_phase(1'b0, r_mm, 1'b0);
      // m*n words treated as one big integer plus one
      w = '0;
      for (int i = 0; i < N; i++) w[i*K +: K] = r_mm[i];
      w = w + 1'b1;
      for (int i = 0; i < N; i++) exp_mmx.push_back({r_me[i], w[i*K +: K]});
      for (int t = 0; t < 20 && mmx_q.size() < 2 * N; t++) tick();
      chk("feed_words", mmx_q.size(), 2 * N);
      for (int i = 0; i < N; i++) begin
        bus.mm_res_valid_i = 1'b1;
        bus.mm_res_i = r_cb[i];
        exp_out.push_back(r_cb[i]);
        tick();
      end
      bus.mm_res_valid_i = 1'b0;
    end
    wait_done_and_check(cmd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.task_cmd_i = '0; bus.task_req_i = 1'b0;
    bus.in_a_i = '0; bus.in_b_i = '0; bus.in_valid_i = 1'b0;
    bus.me_res_i = '0; bus.me_res_valid_i = 1'b0;
    bus.mm_res_i = '0; bus.mm_res_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {22'd0, bus.task_busy_o, bus.in_ready_o, bus.me_start_o, bus.mm_start_o,
        bus.me_xy_valid_o, bus.mm_xy_valid_o, bus.out_valid_o, bus.out_last_o,
        bus.task_done_o, bus.task_err_o}, 0);
    chk("rst_data", {8'd0, bus.out_data_o, bus.mm_x_o, bus.mm_y_o}, 0);
    rst_n = 1'b1;
    tick();

    run_task(3'b111, 1'b0);

    randomize_res();
    r_mm[0] = 8'h11; r_mm[1] = 8'h22; r_mm[2] = 8'h33; r_mm[3] = 8'h44;
    run_task(3'b010, 1'b0);

    // in_valid held for 6 cycles in MM_RUN
    clear_mon();
    bus.task_cmd_i = 3'b010;
    bus.task_req_i = 1'b1;
    tick();
    bus.task_req_i = 1'b0;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_a_i = K'(i + 1);
      bus.in_b_i = K'($urandom);
      chk("hold_in_ready", {31'd0, bus.in_ready_o}, (i < N) ? 1 : 0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    chk("hold_xy_cnt", mmx_q.size(), N);
    for (int i = 0; i < N; i++) begin
      bus.mm_res_valid_i = 1'b1;
      bus.mm_res_i = K'($urandom);
      tick();
    end
    bus.mm_res_valid_i = 1'b0;
    for (int t = 0; t < 20 && dones == 0; t++) tick();
    chk("hold_done", dones, 1);
    chk("hold_out_cnt", out_q.size(), N);

    randomize_res();
    run_task(3'b011, 1'b1);

    randomize_res();
    r_mm[0] = 8'hFF; r_mm[1] = 8'hFF; r_mm[2] = 8'h05; r_mm[3] = 8'h00;
    run_task(3'b000, 1'b0);

    // reset asserted in the middle of ENC MM_RUN
    clear_mon();
    randomize_res();
    bus.task_cmd_i = 3'b000;
    bus.task_req_i = 1'b1;
    tick();
    bus.task_req_i = 1'b0;
    run_phase(1'b1, r_me, 1'b0);
    bus.in_valid_i = 1'b1;
    bus.in_a_i = K'($urandom);
    bus.in_b_i = K'($urandom);
    tick();
    bus.in_valid_i = 1'b0;
    chk("pre_rst_mm_xyv", {31'd0, bus.mm_xy_valid_o}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {22'd0, bus.task_busy_o, bus.in_ready_o, bus.me_start_o, bus.mm_start_o,
        bus.me_xy_valid_o, bus.mm_xy_valid_o, bus.out_valid_o, bus.out_last_o,
        bus.task_done_o, bus.task_err_o}, 0);
    chk("midrst_data", {8'd0, bus.out_data_o, bus.mm_x_o, bus.mm_y_o}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, bus.task_busy_o}, 0);
    randomize_res();
    run_task(3'b010, 1'b0);

    for (int n = 0; n < 12; n++) begin
      randomize_res();
      run_task(3'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
